hub75_rx: RTL and testbench

- Receive-side model of the HUB75 LED-panel interface: the panel end of what the team's matrix driver produces.
- Oversamples the driver's shift clock, latch, output-enable, row address and six colour lines on the system clock.
- Rebuilds each shifted row and streams it out as per-pixel writes with valid/ready, for loopback checking of the driver and a future framebuffer capture path.

---
 rtl/hub75_rx.sv | 137 +++++++++++++
 tb/tb_hub75_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: oversamples the driver's pins, rebuilds each shifted row and
// streams it out as per-pixel valid/ready writes, flagging short rows and early latches.
module hub75_rx #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ROWS  = 8,
  parameter int unsigned ABW   = 3,
  parameter int unsigned CW    = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           hub_clk,
  input  logic           hub_lat,
  input  logic           hub_oe,
  input  logic [ABW-1:0] hub_abc,
  input  logic [5:0]     hub_rgb,
  output logic           wr_valid,
  input  logic           wr_ready,
  output logic [ABW-1:0] wr_row,
  output logic [CW-1:0]  wr_col,
  output logic [5:0]     wr_data,
  output logic           row_done,
  output logic           frame_done,
  output logic [ABW-1:0] lit_row,
  output logic           len_err,
  output logic           overrun_err,
  input  logic           err_clear
);

  localparam int unsigned SW = ABW + 9;
  localparam logic [CW:0] CNT_FULL = (CW + 1)'(WIDTH);
  localparam logic [CW:0] CNT_SAT = (CW + 1)'(WIDTH + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [ABW-1:0] ROW_LAST = ABW'(ROWS - 1);

  typedef enum logic {StIdle, StDrain} state_e;

  state_e r_state, w_state_next;

  // All pins share one synchronizer so data, address and oe stay aligned with the strobes.
  logic [SW-1:0] r_s1, r_s2;
  logic [1:0]    r_s3;

  logic [WIDTH*6-1:0] r_sr, r_buf, w_sr_next;
  logic [CW:0]        r_cnt, w_cnt_inc;
  logic [CW-1:0]      r_col;
  logic [ABW-1:0]     r_row, r_lit;
  logic               r_len_err, r_ovr_err;

  logic           w_clk_rise, w_lat_rise, w_oe, w_hs, w_last, w_accept;
  logic [ABW-1:0] w_abc;
  logic [5:0]     w_rgb;

  assign w_clk_rise = r_s2[SW-1] & ~r_s3[1];
  assign w_lat_rise = r_s2[SW-2] & ~r_s3[0];
  assign w_oe       = r_s2[SW-3];
  assign w_abc      = r_s2[ABW+5:6];
  assign w_rgb      = r_s2[5:0];

  // First-shifted pixel migrates up to column WIDTH-1.
  assign w_sr_next = w_clk_rise ? {r_sr[WIDTH*6-7:0], w_rgb} : r_sr;
  assign w_cnt_inc = (w_clk_rise && r_cnt != CNT_SAT) ? r_cnt + 1'b1 : r_cnt;

  assign wr_valid   = (r_state == StDrain);
  assign w_hs       = wr_valid & wr_ready;
  assign w_last     = (r_col == COL_LAST);
  assign row_done   = w_hs & w_last;
  assign frame_done = row_done & (r_row == ROW_LAST);

  assign wr_row      = r_row;
  assign wr_col      = r_col;
  assign wr_data     = r_buf[int'(r_col)*6 +: 6];
  assign lit_row     = r_lit;
  assign len_err     = r_len_err;
  assign overrun_err = r_ovr_err;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_lat_rise) begin
          w_accept     = 1'b1;
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_hs && w_last) w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3      <= '0;
      r_sr      <= '0;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_lit     <= '0;
      r_len_err <= 1'b0;
      r_ovr_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s1    <= {hub_clk, hub_lat, hub_oe, hub_abc, hub_rgb};
      r_s2    <= r_s1;
      r_s3    <= r_s2[SW-1:SW-2];
      r_sr    <= w_sr_next;

      // Accepted latch takes the same-cycle shift, and its count reset overrides the increment.
      if (w_accept) begin
        r_buf <= w_sr_next;
        r_row <= w_abc;
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end

      if (w_accept) r_col <= '0;
      else if (w_hs) r_col <= w_last ? '0 : r_col + 1'b1;

      if (w_oe) r_lit <= w_abc;

      if (err_clear) begin
        r_len_err <= 1'b0;
        r_ovr_err <= 1'b0;
      end else begin
        if (w_accept && w_cnt_inc != CNT_FULL) r_len_err <= 1'b1;
        if (w_lat_rise && r_state == StDrain) r_ovr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: table of row scenarios plus random rows, checked against a
// pixel-history model of what the panel should have received.
module tb_hub75_rx;

  localparam int WIDTH = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       hub_clk, hub_lat, hub_oe, err_clear;
  logic [2:0] hub_abc;
  logic [5:0] hub_rgb;
  logic       wr_valid, wr_ready, row_done, frame_done, len_err, overrun_err;
  logic [2:0] wr_row, lit_row;
  logic [4:0] wr_col;
  logic [5:0] wr_data;

  hub75_rx #(.WIDTH(32), .ROWS(8), .ABW(3), .CW(5)) dut (
    .clk(clk), .reset(reset), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
    .hub_abc(hub_abc), .hub_rgb(hub_rgb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .row_done(row_done),
    .frame_done(frame_done), .lit_row(lit_row), .len_err(len_err),
    .overrun_err(overrun_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] row;
    logic [4:0] col;
    logic [5:0] data;
    logic       rd;
    logic       fd;
  } hs_t;

  typedef struct {
    int n; int extra; int abc; int mode; int ovr_at;
    bit rnd; bit clr; bit exp_len; bit exp_ovr; bit exp_frame;
  } row_t;

  int checks = 0, errors = 0;
  int ready_mode = 0, phase = 0;
  int rd_total = 0, fd_total = 0;
  hs_t hs_q[$];
  logic [5:0] hist[$];  // most recent WIDTH shifted pixels, oldest first
  int shift_cnt = 0;
  logic [5:0] exp_buf[WIDTH];
  int exp_row;
  row_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  // Sink ready pattern: 0 always, 1 = 1,0,0,1 repeating, 2 random.
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      case (ready_mode)
        0: wr_ready = 1'b1;
        1: wr_ready = (phase % 4 == 0) || (phase % 4 == 3);
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Handshake collector and stall-stability checker.
  initial begin
    logic p_stall, p_rst;
    logic [2:0] p_row;
    logic [4:0] p_col;
    logic [5:0] p_data;
    p_stall = 1'b0;
    p_rst = 1'b1;
    p_row = '0;
    p_col = '0;
    p_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (p_stall && !p_rst)
          chk("stall_hold", int'({wr_valid, wr_row, wr_col, wr_data}),
              int'({1'b1, p_row, p_col, p_data}));
        if (wr_valid && wr_ready) hs_q.push_back('{wr_row, wr_col, wr_data, row_done, frame_done});
        if (row_done) rd_total++;
        if (frame_done) fd_total++;
      end
      p_stall = wr_valid && !wr_ready;
      p_rst = reset;
      p_row = wr_row;
      p_col = wr_col;
      p_data = wr_data;
    end
  end

  task automatic shift_px(input logic [5:0] d);
    hub_rgb = d;
    wait_n(2);
    hub_clk = 1'b1;
    hist.push_back(d);
    if (hist.size() > WIDTH) void'(hist.pop_front());
    shift_cnt++;
    wait_n(2);
    hub_clk = 1'b0;
  endtask

  task automatic pulse_lat();
    hub_lat = 1'b1;
    wait_n(2);
    hub_lat = 1'b0;
    wait_n(2);
  endtask

  // Column c holds the pixel shifted c places before the last one.
  task automatic latch_row(input int abc);
    hub_abc = 3'(abc);
    for (int c = 0; c < WIDTH; c++)
      exp_buf[c] = (c < hist.size()) ? hist[hist.size() - 1 - c] : 6'd0;
    exp_row = abc;
    shift_cnt = 0;
    pulse_lat();
  endtask

  task automatic wait_hs(input int k);
    int t;
    t = 0;
    while (hs_q.size() < k && t < 3000) begin
      tick();
      t++;
    end
    if (hs_q.size() < k) chk("hs_timeout", hs_q.size(), k);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(wr_valid), 0);
    chk({tag, "_rowcol"}, int'({wr_row, wr_col}), 0);
    chk({tag, "_data"}, int'(wr_data), 0);
    chk({tag, "_done"}, int'({row_done, frame_done}), 0);
    chk({tag, "_errs"}, int'({len_err, overrun_err}), 0);
    chk({tag, "_lit"}, int'(lit_row), 0);
  endtask

  task automatic run_row(input row_t r);
    int rd0, fd0;
    hs_q.delete();
    rd0 = rd_total;
    fd0 = fd_total;
    ready_mode = r.mode;
    for (int i = 0; i < r.n; i++) shift_px(r.rnd ? 6'($urandom) : 6'(i));
    latch_row(r.abc);
    if (r.ovr_at >= 0) begin
      wait_hs(r.ovr_at);
      for (int i = 0; i < r.extra; i++) shift_px(6'($urandom));
      pulse_lat();
    end
    wait_hs(WIDTH);
    wait_n(10);
    chk("hs_count", hs_q.size(), WIDTH);
    for (int i = 0; i < hs_q.size() && i < WIDTH; i++) begin
      chk($sformatf("col[%0d]", i), int'(hs_q[i].col), i);
      chk($sformatf("data[%0d]", i), int'(hs_q[i].data), int'(exp_buf[i]));
      chk($sformatf("row[%0d]", i), int'(hs_q[i].row), exp_row);
      chk($sformatf("row_done[%0d]", i), int'(hs_q[i].rd), int'(i == WIDTH - 1));
      chk($sformatf("frame_done[%0d]", i), int'(hs_q[i].fd),
          int'(i == WIDTH - 1 && r.exp_frame));
    end
    chk("row_done_pulses", rd_total - rd0, 1);
    chk("frame_done_pulses", fd_total - fd0, int'(r.exp_frame));
    chk("len_err", int'(len_err), int'(r.exp_len));
    chk("overrun_err", int'(overrun_err), int'(r.exp_ovr));
    if (r.clr) begin
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("err_cleared", int'({len_err, overrun_err}), 0);
    end
  endtask

  initial begin
    int rd0;
    row_t rr;
    tbl[0] = '{32, 0, 6, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // clean row, always ready
    tbl[1] = '{32, 0, 6, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // stalling sink
    tbl[2] = '{31, 0, 6, 0, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};  // short row
    tbl[3] = '{32, 2, 6, 0, 10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // overrun latch at col 10
    tbl[4] = '{30, 0, 6, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // 2 carried shifts make 32
    tbl[5] = '{32, 0, 7, 2, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // last row -> frame_done
    tbl[6] = '{32, 0, 0, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    hub_clk = 1'b0;
    hub_lat = 1'b0;
    hub_oe = 1'b0;
    hub_abc = '0;
    hub_rgb = '0;
    err_clear = 1'b0;
    wait_n(4);
    reset = 1'b0;
    chk_zero("reset");

    // Reset in the middle of a drain abandons it without row_done.
    ready_mode = 0;
    for (int i = 0; i < WIDTH; i++) shift_px(6'($urandom));
    latch_row(5);
    wait_hs(5);
    rd0 = rd_total;
    reset = 1'b1;
    tick();
    chk_zero("middrain");
    chk("middrain_no_row_done", rd_total, rd0);
    reset = 1'b0;
    hist.delete();
    shift_cnt = 0;
    wait_n(3);
    chk("post_reset_idle", int'(wr_valid), 0);

    for (int k = 0; k < 7; k++) run_row(tbl[k]);

    for (int k = 0; k < 6; k++) begin
      rr.n = $urandom_range(WIDTH - 2, WIDTH + 2);
      rr.extra = 0;
      rr.abc = $urandom_range(0, 7);
      rr.mode = 2;
      rr.ovr_at = -1;
      rr.rnd = 1'b1;
      rr.clr = 1'b1;
      rr.exp_len = (rr.n != WIDTH);
      rr.exp_ovr = 1'b0;
      rr.exp_frame = (rr.abc == 7);
      run_row(rr);
    end

    hub_oe = 1'b1;
    hub_abc = 3'd5;
    wait_n(3);
    chk("lit_row_capture", int'(lit_row), 5);
    hub_oe = 1'b0;
    hub_abc = 3'd2;
    wait_n(5);
    chk("lit_row_hold", int'(lit_row), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
